// File: rtl/adder_char_stimgen_pkg.sv
// Shared definitions for the adder characterisation stimulus engine:
// activity-pattern encodings, FSM states, LFSR feedback taps and the
// toggle-accumulator saturation value.
package adder_char_pkg;

  typedef enum logic [1:0] {
    MODE_ZERO = 2'd0,  // word held at zero: no switching
    MODE_FULL = 2'd1,  // all-zero <-> all-ones: every bit toggles
    MODE_HALF = 2'd2,  // all-zero <-> 0101..: half the bits toggle
    MODE_RAND = 2'd3   // LFSR-driven pseudo-random words
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Galois right-shift feedback polynomial for the 32-bit LFSR.
  localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;

  // Ceiling of the operand toggle accumulator.
  localparam logic [31:0] TOGGLE_SAT = 32'hFFFF_FFFF;

endpackage

// File: rtl/adder_char_stimgen_popcount_tree.sv
// Combinational population count of a W-bit vector.
// Ports:
//   i_vec    in  W               vector to count
//   o_count  out $clog2(W+1)     number of ones in i_vec
module popcount_tree #(
  parameter int W = 24
) (
  input  logic [W-1:0]         i_vec,
  output logic [$clog2(W+1)-1:0] o_count
);

  localparam int CW = $clog2(W + 1);

  always_comb begin
    // NOTE: every always_comb output gets a default before any branch or
    // loop touches it, so no path can leave it unassigned and infer a latch.
    o_count = '0;
    for (int i = 0; i < W; i++) begin
      o_count = o_count + CW'(i_vec[i]);
    end
  end

endmodule

// File: rtl/adder_char_stimgen.sv
// Stimulus and activity engine for adder energy characterisation.
// Emits packets of operand flits separated by programmable idle gaps,
// feeds them through a registered N-bit adder, and accumulates the
// number of operand bit toggles in hardware.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 one-cycle run request, honoured only in IDLE
//   mode                  activity pattern (see mode_e)
//   payload_len/gap_len/num_pkts  run configuration, latched on start
//   op_a/op_b/op_valid    operand flit presented to the adder
//   sum_q/carry_q/sum_valid  registered adder result
//   busy/done             run status; done pulses once at end of run
//   pkt_cnt               packets completed in the current run
//   toggle_acc            saturating operand bit-toggle count
module adder_char_stimgen
  import adder_char_pkg::*;
#(
  parameter int                N      = 12,
  parameter int                LFSR_W = 32,
  parameter logic [LFSR_W-1:0] SEED   = 32'h0000_0001,
  parameter int                CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] payload_len,
  input  logic [CNT_W-1:0] gap_len,
  input  logic [CNT_W-1:0] num_pkts,
  output logic [N-1:0]     op_a,
  output logic [N-1:0]     op_b,
  output logic             op_valid,
  output logic [N-1:0]     sum_q,
  output logic             carry_q,
  output logic             sum_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [31:0]      toggle_acc
);

  localparam int                W2      = 2 * N;
  localparam int                PC_W    = $clog2(W2 + 1);
  localparam logic [W2-1:0]     CHECKER = {N{2'b01}};
  localparam logic [LFSR_W-1:0] TAPS    = LFSR_TAPS[LFSR_W-1:0];

  state_e            r_state, w_state_nxt;
  mode_e             r_mode;
  logic [CNT_W-1:0]  r_payload, r_gap, r_num;
  logic [CNT_W-1:0]  r_flit_cnt, r_gap_cnt, r_pkt_cnt;
  logic              r_phase;
  logic [LFSR_W-1:0] r_lfsr, w_lfsr_step;
  logic [N-1:0]      r_op_a, r_op_b, r_sum;
  logic              r_op_valid, r_carry, r_sum_valid, r_done;
  logic [31:0]       r_toggle_acc, w_acc_next;
  logic [32:0]       w_acc_sum;
  logic [W2-1:0]     w_word;
  logic [PC_W-1:0]   w_pop;
  logic              w_last_flit, w_last_pkt, w_gap_end;

  assign w_last_flit = (r_flit_cnt == r_payload - CNT_W'(1));
  assign w_last_pkt  = (r_pkt_cnt + CNT_W'(1) == r_num);
  assign w_gap_end   = (r_gap_cnt == r_gap - CNT_W'(1));

  // One Galois right-shift step; only consumed in MODE_RAND.
  assign w_lfsr_step = {1'b0, r_lfsr[LFSR_W-1:1]} ^ (r_lfsr[0] ? TAPS : '0);

  // Pattern generator. r_phase is 0 on a packet's first flit, so the
  // alternating modes always open a packet with their non-zero word.
  always_comb begin
    w_word = '0;
    unique case (r_mode)
      MODE_ZERO: w_word = '0;
      MODE_FULL: w_word = r_phase ? '0 : '1;
      MODE_HALF: w_word = r_phase ? '0 : CHECKER;
      MODE_RAND: w_word = w_lfsr_step[W2-1:0];
      default:   w_word = '0;
    endcase
  end

  popcount_tree #(.W(W2)) u_popcount (
    .i_vec   (w_word ^ {r_op_b, r_op_a}),
    .o_count (w_pop)
  );

  // One guard bit detects overflow; clamp instead of wrapping.
  assign w_acc_sum  = {1'b0, r_toggle_acc} + 33'(w_pop);
  assign w_acc_next = w_acc_sum[32] ? TOGGLE_SAT : w_acc_sum[31:0];

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:
        if (start) begin
          w_state_nxt = (payload_len == '0 || num_pkts == '0) ? ST_DONE : ST_SEND;
        end
      ST_SEND:
        if (w_last_flit) begin
          if (w_last_pkt)        w_state_nxt = ST_DONE;
          else if (r_gap != '0)  w_state_nxt = ST_GAP;
          else                   w_state_nxt = ST_SEND;
        end
      ST_GAP:
        if (w_gap_end) w_state_nxt = ST_SEND;
      ST_DONE:
        w_state_nxt = ST_IDLE;
      default:
        w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode       <= MODE_ZERO;
      r_payload    <= '0;
      r_gap        <= '0;
      r_num        <= '0;
      r_flit_cnt   <= '0;
      r_gap_cnt    <= '0;
      r_pkt_cnt    <= '0;
      r_phase      <= 1'b0;
      r_lfsr       <= SEED;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_valid   <= 1'b0;
      r_toggle_acc <= '0;
      r_sum        <= '0;
      r_carry      <= 1'b0;
      r_sum_valid  <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_op_valid  <= 1'b0;
      r_done      <= (r_state == ST_DONE);
      r_sum_valid <= r_op_valid;
      if (r_op_valid) {r_carry, r_sum} <= {1'b0, r_op_a} + {1'b0, r_op_b};

      unique case (r_state)
        ST_IDLE:
          if (start) begin
            r_mode       <= mode_e'(mode);
            r_payload    <= payload_len;
            r_gap        <= gap_len;
            r_num        <= num_pkts;
            r_pkt_cnt    <= '0;
            r_toggle_acc <= '0;
            r_lfsr       <= SEED;
            r_phase      <= 1'b0;
            r_flit_cnt   <= '0;
            r_gap_cnt    <= '0;
          end
        ST_SEND: begin
          r_op_valid       <= 1'b1;
          {r_op_b, r_op_a} <= w_word;
          r_toggle_acc     <= w_acc_next;
          if (r_mode == MODE_RAND) r_lfsr <= w_lfsr_step;
          if (w_last_flit) begin
            r_flit_cnt <= '0;
            r_phase    <= 1'b0;
            r_pkt_cnt  <= r_pkt_cnt + CNT_W'(1);
          end else begin
            r_flit_cnt <= r_flit_cnt + CNT_W'(1);
            r_phase    <= ~r_phase;
          end
        end
        ST_GAP:
          r_gap_cnt <= w_gap_end ? '0 : r_gap_cnt + CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign op_a       = r_op_a;
  assign op_b       = r_op_b;
  assign op_valid   = r_op_valid;
  assign sum_q      = r_sum;
  assign carry_q    = r_carry;
  assign sum_valid  = r_sum_valid;
  assign busy       = (r_state == ST_SEND) || (r_state == ST_GAP);
  assign done       = r_done;
  assign pkt_cnt    = r_pkt_cnt;
  assign toggle_acc = r_toggle_acc;

endmodule
